// File: rtl/z80_bus_seq_if.sv
// Bus bundle between the tv80 core control outputs, the bus-cycle sequencer
// and the external memory/IO bus. The master side is the core plus the bus
// environment. The slave side is the sequencer.
interface z80_bus_seq_if #(
    parameter int DW = 8
);
    logic [6:0]    mcycle;
    logic [6:0]    tstate;
    logic          intcycle_n;
    logic          no_read;
    logic          write;
    logic          iorq;
    logic          rfsh_n;
    logic          wait_n;
    logic          core_wait_n;
    logic [DW-1:0] di;
    logic [DW-1:0] di_reg;
    logic          mreq_n;
    logic          iorq_n;
    logic          rd_n;
    logic          wr_n;
    logic [2:0]    wcnt_o;

    modport master (
        output mcycle, tstate, intcycle_n, no_read, write, iorq, rfsh_n,
               wait_n, di,
        input  core_wait_n, di_reg, mreq_n, iorq_n, rd_n, wr_n, wcnt_o
    );

    modport slave (
        input  mcycle, tstate, intcycle_n, no_read, write, iorq, rfsh_n,
               wait_n, di,
        output core_wait_n, di_reg, mreq_n, iorq_n, rd_n, wr_n, wcnt_o
    );
endinterface

// File: rtl/z80_bus_seq.sv
// Z80 bus-cycle sequencer. It turns tv80 machine-cycle/T-state indications
// into registered bus strobes, which update on the falling edge. It inserts
// programmable wait states per cycle type, merges them with the external
// wait_n, and latches read data for the core on the rising edge.
module z80_bus_seq #(
    parameter bit          T2WRITE     = 1'b0,
    parameter int unsigned MEM_WAIT    = 0,
    parameter int unsigned IO_WAIT     = 0,
    parameter int unsigned M1_WAIT     = 0,
    parameter bit          RFSH_STROBE = 1'b1,
    parameter int          DW          = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cep,
    input  logic          cen,
    z80_bus_seq_if.slave  bus
);
    localparam logic [2:0] MEM_W = 3'(MEM_WAIT);
    localparam logic [2:0] IO_W  = 3'(IO_WAIT);
    localparam logic [2:0] M1_W  = 3'(M1_WAIT);

    logic          m1;
    logic          m_other;
    logic          t1;
    logic          t2;
    logic          t3;
    logic          t4;
    logic          core_wait_n;
    logic [2:0]    wcnt;
    logic [DW-1:0] di_q;
    logic          mreq_d;
    logic          iorq_d;
    logic          rd_d;
    logic          wr_d;
    logic          mreq_q;
    logic          iorq_q;
    logic          rd_q;
    logic          wr_q;
    logic          unused_tstate;

    // Wait states owed by the cycle that is starting in T1.
    function automatic logic [2:0] wait_load(input logic is_m1, input logic intc_n,
                                             input logic io, input logic nrd,
                                             input logic wr);
        if (is_m1)
            return intc_n ? M1_W : IO_W;
        if (io)
            return IO_W;
        if (nrd && !wr)
            return 3'd0;
        return MEM_W;
    endfunction

    assign m1      = bus.mcycle[0];
    assign m_other = |bus.mcycle[6:1];
    assign t1      = bus.tstate[0];
    assign t2      = bus.tstate[1];
    assign t3      = bus.tstate[2];
    assign t4      = bus.tstate[3];

    // T5..T7 never carry bus activity.
    assign unused_tstate = ^bus.tstate[6:4];

    // The core only sees a ready bus when the internal count has expired.
    assign core_wait_n = bus.wait_n & (wcnt == 3'd0);

    // Next strobe levels from the current machine cycle and T-state.
    always_comb begin
        mreq_d = 1'b1;
        iorq_d = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        if (m1) begin
            // The refresh address is on the bus in T3/T4. The fetch strobes are dropped in T3.
            if (RFSH_STROBE && !bus.rfsh_n && (t3 || t4)) begin
                mreq_d = 1'b0;
            end else if (t2 || t3) begin
                if (bus.intcycle_n) begin
                    mreq_d = 1'b0;
                    rd_d   = 1'b0;
                end else begin
                    iorq_d = 1'b0;
                end
            end
        end else if (m_other) begin
            if (bus.write) begin
                if (t2 || t3) begin
                    iorq_d = !bus.iorq;
                    mreq_d = bus.iorq;
                end
                if (T2WRITE)
                    wr_d = !(t2 || (t3 && !core_wait_n));
                else
                    wr_d = !t3;
            end else if (!bus.no_read && (t2 || t3)) begin
                rd_d   = 1'b0;
                iorq_d = !bus.iorq;
                mreq_d = bus.iorq;
            end
        end
    end

    // Strobes register on the falling edge; reset releases them even without cen.
    always_ff @(negedge clk) begin
        if (!reset_n) begin
            mreq_q <= 1'b1;
            iorq_q <= 1'b1;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
        end else if (cen) begin
            mreq_q <= mreq_d;
            iorq_q <= iorq_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
    end

    // Wait counter: load in T1 and count down once per enabled T2/Tw.
    always_ff @(posedge clk) begin
        if (!reset_n)
            wcnt <= 3'd0;
        else if (cep) begin
            if (t1)
                wcnt <= wait_load(m1, bus.intcycle_n, bus.iorq, bus.no_read, bus.write);
            else if (t2 && (wcnt != 3'd0))
                wcnt <= wcnt - 3'd1;
        end
    end

    // Capture read data on the edge that ends a ready T3.
    always_ff @(posedge clk) begin
        if (!reset_n)
            di_q <= '0;
        else if (cep && t3 && core_wait_n)
            di_q <= bus.di;
    end

    assign bus.core_wait_n = core_wait_n;
    assign bus.di_reg      = di_q;
    assign bus.mreq_n      = mreq_q;
    assign bus.iorq_n      = iorq_q;
    assign bus.rd_n        = rd_q;
    assign bus.wr_n        = wr_q;
    assign bus.wcnt_o      = wcnt;
endmodule

// File: tb/tb_z80_bus_seq.sv
// Bench for z80_bus_seq. Two instances use different parameter sets.
// The bench plays the tv80 core for whichever instance it follows: it steps
// T-states on enabled rising edges and stays in T2 while core_wait_n is low.
// Each T-state is checked against a per-cycle-type strobe table and
// wait-count rules.
module tb_z80_bus_seq;
    logic       clk;
    logic       reset_n;
    logic       cep;
    logic       cen;
    logic [6:0] mcycle;
    logic [6:0] tstate;
    logic       intcycle_n;
    logic       no_read;
    logic       write;
    logic       iorq;
    logic       rfsh_n;
    logic       wait_n;
    logic [7:0] di;

    int n_pass;
    int n_total;
    int sel;
    int k;
    int div;
    bit en_off;

    z80_bus_seq_if #(.DW(8)) bus_a ();
    z80_bus_seq_if #(.DW(8)) bus_b ();

    assign bus_a.mcycle = mcycle;     assign bus_b.mcycle = mcycle;
    assign bus_a.tstate = tstate;     assign bus_b.tstate = tstate;
    assign bus_a.intcycle_n = intcycle_n; assign bus_b.intcycle_n = intcycle_n;
    assign bus_a.no_read = no_read;   assign bus_b.no_read = no_read;
    assign bus_a.write = write;       assign bus_b.write = write;
    assign bus_a.iorq = iorq;         assign bus_b.iorq = iorq;
    assign bus_a.rfsh_n = rfsh_n;     assign bus_b.rfsh_n = rfsh_n;
    assign bus_a.wait_n = wait_n;     assign bus_b.wait_n = wait_n;
    assign bus_a.di = di;             assign bus_b.di = di;

    // Instance A: T2WRITE=0, MEM 4, IO 1, M1 2, refresh strobe on
    z80_bus_seq #(.T2WRITE(1'b0), .MEM_WAIT(4), .IO_WAIT(1), .M1_WAIT(2),
                  .RFSH_STROBE(1'b1), .DW(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .cep(cep), .cen(cen), .bus(bus_a));

    // Instance B: T2WRITE=1, MEM 0, IO 3, M1 7, refresh strobe off
    z80_bus_seq #(.T2WRITE(1'b1), .MEM_WAIT(0), .IO_WAIT(3), .M1_WAIT(7),
                  .RFSH_STROBE(1'b0), .DW(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .cep(cep), .cen(cen), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] obs_str(input int d);
        if (d == 0) return {bus_a.mreq_n, bus_a.iorq_n, bus_a.rd_n, bus_a.wr_n};
        return {bus_b.mreq_n, bus_b.iorq_n, bus_b.rd_n, bus_b.wr_n};
    endfunction

    function automatic logic [2:0] obs_wcnt(input int d);
        return (d == 0) ? bus_a.wcnt_o : bus_b.wcnt_o;
    endfunction

    function automatic logic obs_cw(input int d);
        return (d == 0) ? bus_a.core_wait_n : bus_b.core_wait_n;
    endfunction

    function automatic logic [7:0] obs_di(input int d);
        return (d == 0) ? bus_a.di_reg : bus_b.di_reg;
    endfunction

    // Cycle kinds: 0 fetch, 1 int-ack, 2 mem rd, 3 mem wr, 4 io rd, 5 io wr, 6 no-read
    function automatic int nwait_of(input int d, input int kind);
        case (kind)
            0:       return (d == 0) ? 2 : 7;
            1, 4, 5: return (d == 0) ? 1 : 3;
            2, 3:    return (d == 0) ? 4 : 0;
            default: return 0;
        endcase
    endfunction

    // Expected {mreq_n, iorq_n, rd_n, wr_n} per phase: 0=T1, 1=T2/Tw, 2=T3, 3=T4
    function automatic logic [3:0] exp_str(input int d, input int kind, input int ph);
        bit t2w;
        bit rf;
        t2w = (d == 1);
        rf  = (d == 0);
        if (ph == 0) return 4'b1111;
        case (kind)
            0: begin
                if (ph == 1) return 4'b0101;
                if (ph == 2) return rf ? 4'b0111 : 4'b0101;
                return rf ? 4'b0111 : 4'b1111;
            end
            1: begin
                if (ph <= 2) return 4'b1011;
                return rf ? 4'b0111 : 4'b1111;
            end
            2: return 4'b0101;
            3: begin
                if (ph == 1) return t2w ? 4'b0110 : 4'b0111;
                return t2w ? 4'b0111 : 4'b0110;
            end
            4: return 4'b1001;
            5: begin
                if (ph == 1) return t2w ? 4'b1010 : 4'b1011;
                return t2w ? 4'b1011 : 4'b1010;
            end
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_en();
        if (en_off) begin
            cep = 1'b0;
            cen = 1'b0;
        end else begin
            cep = ((k % div) == 0);
            cen = ((k % div) == (div / 2));
        end
    endtask

    task automatic neg_half();
        logic [3:0] s0;
        s0 = obs_str(sel);
        @(negedge clk);
        #1;
        if (reset_n && !cen) check("gate_strobe", obs_str(sel), s0);
    endtask

    task automatic pos_half(output bit adv);
        logic [2:0] w0;
        w0 = obs_wcnt(sel);
        @(posedge clk);
        #1;
        adv = cep;
        if (reset_n && !cep) check("gate_wcnt", obs_wcnt(sel), w0);
        k++;
        set_en();
    endtask

    task automatic new_rate(input int r);
        div = r;
        k   = 1;
        set_en();
    endtask

    task automatic run_mcycle(input int d, input int kind, input int ext,
                              input logic [7:0] dval, input string nm);
        int nw;
        int mx;
        int j;
        bit adv;
        bit cw;
        logic [7:0] held;
        sel  = d;
        nw   = nwait_of(d, kind);
        mx   = (nw > ext) ? nw : ext;
        held = obs_di(d);
        mcycle     = (kind <= 1) ? 7'b0000001 : 7'b0000010;
        intcycle_n = (kind != 1);
        iorq       = (kind == 4 || kind == 5);
        write      = (kind == 3 || kind == 5);
        no_read    = (kind == 6) ? 1'b1 : (write ? 1'($urandom_range(1)) : 1'b0);
        rfsh_n     = 1'b1;
        wait_n     = 1'b1;
        di         = 8'($urandom);
        tstate     = 7'b0000001;
        do begin
            neg_half();
            if (cep) begin
                check({nm, "_t1_strobe"}, obs_str(d), exp_str(d, kind, 0));
                check({nm, "_t1_di_hold"}, obs_di(d), held);
            end
            pos_half(adv);
        end while (!adv);
        check({nm, "_wcnt_load"}, obs_wcnt(d), 32'(nw));

        tstate = 7'b0000010;
        j = 0;
        forever begin
            wait_n = (j >= ext);
            cw = 1'b0;
            do begin
                neg_half();
                if (cep) begin
                    check($sformatf("%s_t2_strobe_w%0d", nm, j), obs_str(d), exp_str(d, kind, 1));
                    check($sformatf("%s_t2_wcnt_w%0d", nm, j), obs_wcnt(d),
                          32'((nw > j) ? (nw - j) : 0));
                    check($sformatf("%s_t2_cwait_w%0d", nm, j), obs_cw(d),
                          32'((j >= nw) && (j >= ext)));
                    cw = obs_cw(d);
                end
                pos_half(adv);
            end while (!adv);
            if (cw) break;
            j++;
            if (j > 24) begin
                check({nm, "_t2_timeout"}, 32'(cw), 32'd1);
                break;
            end
        end
        check({nm, "_wait_states"}, 32'(j), 32'(mx));

        check({nm, "_t3_entry_strobe"}, obs_str(d), exp_str(d, kind, 1));
        tstate = 7'b0000100;
        wait_n = 1'b1;
        rfsh_n = (kind == 0) ? 1'b0 : 1'b1;
        di     = dval;
        do begin
            neg_half();
            if (cep) check({nm, "_t3_strobe"}, obs_str(d), exp_str(d, kind, 2));
            pos_half(adv);
        end while (!adv);
        check({nm, "_di_latch"}, obs_di(d), dval);

        if (kind <= 1) begin
            tstate = 7'b0001000;
            rfsh_n = 1'b0;
            di     = 8'($urandom);
            do begin
                neg_half();
                if (cep) check({nm, "_t4_strobe"}, obs_str(d), exp_str(d, kind, 3));
                pos_half(adv);
            end while (!adv);
            check({nm, "_t4_di_hold"}, obs_di(d), dval);
        end
        rfsh_n = 1'b1;
    endtask

    initial begin
        bit adv;
        int d;
        int kind;
        int ext;
        n_pass     = 0;
        n_total    = 0;
        sel        = 0;
        k          = 0;
        div        = 1;
        en_off     = 1'b0;
        reset_n    = 1'b0;
        cep        = 1'b1;
        cen        = 1'b1;
        mcycle     = 7'b0000001;
        tstate     = 7'b0000001;
        intcycle_n = 1'b1;
        no_read    = 1'b0;
        write      = 1'b0;
        iorq       = 1'b0;
        rfsh_n     = 1'b1;
        wait_n     = 1'b1;
        di         = 8'h00;

        // Power-up reset with both enables high
        repeat (3) @(posedge clk);
        #1;
        check("por_strobe_a", obs_str(0), 4'hF);
        check("por_strobe_b", obs_str(1), 4'hF);
        check("por_wcnt_a", obs_wcnt(0), 0);
        check("por_wcnt_b", obs_wcnt(1), 0);
        check("por_di_a", obs_di(0), 0);
        check("por_di_b", obs_di(1), 0);
        reset_n = 1'b1;

        // Opcode fetch, two programmed waits, refresh in T3/T4
        run_mcycle(0, 0, 0, 8'hA5, "fetch_a");

        // Reset in the middle of an M1 wait, enables held low
        sel        = 0;
        mcycle     = 7'b0000001;
        intcycle_n = 1'b1;
        iorq       = 1'b0;
        write      = 1'b0;
        no_read    = 1'b0;
        tstate     = 7'b0000001;
        do begin neg_half(); pos_half(adv); end while (!adv);
        tstate = 7'b0000010;
        do begin neg_half(); pos_half(adv); end while (!adv);
        check("mid_m1_strobe", obs_str(0), 4'b0101);
        check("mid_m1_wcnt", obs_wcnt(0), 1);
        check("mid_m1_di", obs_di(0), 8'hA5);
        reset_n = 1'b0;
        en_off  = 1'b1;
        set_en();
        repeat (3) begin neg_half(); pos_half(adv); end
        check("rst_strobe_a", obs_str(0), 4'hF);
        check("rst_strobe_b", obs_str(1), 4'hF);
        check("rst_wcnt_a", obs_wcnt(0), 0);
        check("rst_di_a", obs_di(0), 0);
        check("rst_di_b", obs_di(1), 0);
        reset_n = 1'b1;
        en_off  = 1'b0;
        new_rate(1);

        // Directed cycle types at full rate
        run_mcycle(0, 0, 0, 8'h3C, "fetch_after_rst");
        run_mcycle(0, 5, 0, 8'h5A, "iowr_a");
        run_mcycle(1, 3, 3, 8'h81, "memwr_b_ext3");
        run_mcycle(1, 1, 0, 8'hFF, "intack_b");
        run_mcycle(0, 2, 0, 8'h12, "memrd_a");
        run_mcycle(1, 4, 1, 8'h34, "iord_b");
        run_mcycle(0, 6, 0, 8'h56, "noread_a");
        run_mcycle(1, 0, 2, 8'h78, "fetch_b");
        run_mcycle(0, 1, 2, 8'h9A, "intack_a");

        // Same sequence with cep 1-in-4 and cen 1-in-4 offset by 2
        new_rate(4);
        run_mcycle(0, 0, 0, 8'hA5, "g4_fetch_a");
        run_mcycle(0, 5, 0, 8'h5A, "g4_iowr_a");
        run_mcycle(1, 3, 3, 8'h81, "g4_memwr_b");
        run_mcycle(1, 1, 0, 8'hFF, "g4_intack_b");

        // Randomised cycles across both instances and enable rates
        for (int i = 0; i < 36; i++) begin
            if ((i % 12) == 0) begin
                case ($urandom_range(2))
                    0:       new_rate(1);
                    1:       new_rate(3);
                    default: new_rate(4);
                endcase
            end
            d    = int'($urandom_range(1));
            kind = int'($urandom_range(6));
            ext  = int'($urandom_range(3));
            run_mcycle(d, kind, ext, 8'($urandom), $sformatf("rnd%0d_k%0d", i, kind));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
